// File: rtl/mips_fetch_stage_if.sv
// Fetch-stage signal bundle: pipeline controls in, instruction ROM port, IF/ID register out.
// The fetch stage takes the master view; the hazard logic, ROM and decode stage take the slave view.
interface mips_fetch_stage_if;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_raddr;
   logic        imem_ren;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;

   modport master (
      input  stall, flush, redirect_valid, redirect_pc, imem_rdata,
      output imem_raddr, imem_ren, pc_out, if_id_instr, if_id_pc4, if_id_valid, halted
   );

   modport slave (
      output stall, flush, redirect_valid, redirect_pc, imem_rdata,
      input  imem_raddr, imem_ren, pc_out, if_id_instr, if_id_pc4, if_id_valid, halted
   );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC, asynchronous ROM read port, IF/ID register,
// and a BOOT/RUN/HALTED controller that holds off ROM reads until preload and stops on break.
module mips_fetch_stage #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter bit          WORD_ADDR     = 1'b1,
   parameter bit          HALT_ON_BREAK = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   mips_fetch_stage_if.master bus
);

   localparam logic [1:0]  ST_BOOT     = 2'd0;
   localparam logic [1:0]  ST_RUN      = 2'd1;
   localparam logic [1:0]  ST_HALTED   = 2'd2;
   localparam logic [31:0] BREAK_INSTR = 32'h0000_000D;

   logic [1:0]  state_r, state_nxt_s;
   logic [31:0] pc_r, pc_nxt_s;
   logic [31:0] instr_r, instr_nxt_s;
   logic [31:0] pc4_r, pc4_nxt_s;
   logic        valid_r, valid_nxt_s;
   logic [31:0] pc_plus4_s;
   logic [31:0] target_s;
   logic        unused_s;

   function automatic logic is_break(input logic [31:0] word);
      return HALT_ON_BREAK && (word == BREAK_INSTR);
   endfunction

   assign pc_plus4_s = pc_r + 32'd4;
   assign target_s   = {bus.redirect_pc[31:2], 2'b00};
   assign unused_s   = ^bus.redirect_pc[1:0];

   // Next PC, controller state and IF/ID contents; redirect beats stall beats normal fetch.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      instr_nxt_s = instr_r;
      pc4_nxt_s   = pc4_r;
      valid_nxt_s = valid_r;
      case (state_r)
         ST_BOOT: begin
            state_nxt_s = ST_RUN;
            instr_nxt_s = 32'd0;
            pc4_nxt_s   = 32'd0;
            valid_nxt_s = 1'b0;
            if (bus.redirect_valid) begin
               pc_nxt_s = target_s;
            end else begin
               pc_nxt_s = pc_r;
            end
         end
         ST_RUN: begin
            if (bus.redirect_valid) begin
               pc_nxt_s    = target_s;
               instr_nxt_s = 32'd0;
               pc4_nxt_s   = 32'd0;
               valid_nxt_s = 1'b0;
            end else if (bus.stall) begin
               if (bus.flush) begin
                  instr_nxt_s = 32'd0;
                  pc4_nxt_s   = 32'd0;
                  valid_nxt_s = 1'b0;
               end else begin
                  instr_nxt_s = instr_r;
               end
            end else if (bus.flush) begin
               pc_nxt_s    = pc_plus4_s;
               instr_nxt_s = 32'd0;
               pc4_nxt_s   = 32'd0;
               valid_nxt_s = 1'b0;
            end else begin
               instr_nxt_s = bus.imem_rdata;
               pc4_nxt_s   = pc_plus4_s;
               valid_nxt_s = 1'b1;
               // A captured break parks the PC on itself so a debugger sees where fetch stopped.
               if (is_break(bus.imem_rdata)) begin
                  pc_nxt_s    = pc_r;
                  state_nxt_s = ST_HALTED;
               end else begin
                  pc_nxt_s    = pc_plus4_s;
               end
            end
         end
         ST_HALTED: begin
            if (bus.redirect_valid) begin
               pc_nxt_s    = target_s;
               state_nxt_s = ST_RUN;
               instr_nxt_s = 32'd0;
               pc4_nxt_s   = 32'd0;
               valid_nxt_s = 1'b0;
            end else if (bus.stall) begin
               instr_nxt_s = instr_r;
            end else begin
               instr_nxt_s = 32'd0;
               pc4_nxt_s   = 32'd0;
               valid_nxt_s = 1'b0;
            end
         end
         default: begin
            state_nxt_s = ST_BOOT;
            instr_nxt_s = 32'd0;
            pc4_nxt_s   = 32'd0;
            valid_nxt_s = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_BOOT;
         pc_r    <= RESET_PC;
         instr_r <= 32'd0;
         pc4_r   <= 32'd0;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         instr_r <= instr_nxt_s;
         pc4_r   <= pc4_nxt_s;
         valid_r <= valid_nxt_s;
      end
   end

   assign bus.imem_raddr  = WORD_ADDR ? {2'b00, pc_r[31:2]} : pc_r;
   assign bus.imem_ren    = (state_r == ST_RUN);
   assign bus.pc_out      = pc_r;
   assign bus.if_id_instr = instr_r;
   assign bus.if_id_pc4   = pc4_r;
   assign bus.if_id_valid = valid_r;
   assign bus.halted      = (state_r == ST_HALTED);

endmodule

// File: doc/mips_fetch_stage.md
# mips_fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the program counter, drives the asynchronous instruction ROM's read port, and registers the returned word into the IF/ID pipeline register for decode. It sits directly upstream of the instruction ROM and directly downstream of the hazard/branch logic, which supply stall, flush and redirect controls. It includes a small boot/run/halt controller so the ROM is not read until preload completes and fetch stops cleanly on a `break`.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `WORD_ADDR`, 1: 1 = ROM indexed by word, so `imem_raddr = {2'b00, pc[31:2]}`; 0 = byte address, so `imem_raddr = pc`.
- `HALT_ON_BREAK`, 1: 1 = enter HALTED after fetching 32'h0000_000D.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `stall` in 1: hold PC and IF/ID contents.
- `flush` in 1: replace the next IF/ID capture with a bubble.
- `redirect_valid` in 1: load `redirect_pc` into PC (branch/jump taken).
- `redirect_pc` in 32: target address; bits [1:0] are ignored and forced to 0.
- `imem_raddr` out 32: ROM read address.
- `imem_ren` out 1: ROM read enable.
- `imem_rdata` in 32: ROM data, valid combinationally in the same cycle.
- `pc_out` out 32: current PC.
- `if_id_instr` out 32: registered instruction.
- `if_id_pc4` out 32: registered PC+4 of that instruction.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `halted` out 1: controller is in HALTED.

## Operation
- States: BOOT, RUN, HALTED. Reset enters BOOT.
- **BOOT** lasts exactly one cycle. `imem_ren`=0. IF/ID captures a bubble. Next state is RUN.
  - If `redirect_valid` is asserted in BOOT, PC loads the target; the state still moves to RUN.
- **RUN**: `imem_ren`=1. Per-edge priority is redirect > stall > normal.
  - Redirect: PC ← `{redirect_pc[31:2], 2'b00}`. IF/ID ← bubble, regardless of `stall` or `flush`.
  - Stall (no redirect): PC holds. IF/ID holds, or becomes a bubble if `flush`=1.
  - Normal: PC ← PC+4, mod 2^32, so 32'hFFFF_FFFC wraps to 0. IF/ID ← {`imem_rdata`, PC+4, valid=1}, or a bubble if `flush`=1.
  - Break: a normal capture with `HALT_ON_BREAK`=1 and `imem_rdata`=32'h0000_000D loads IF/ID normally (valid=1). PC holds at the `break` address and the state goes to HALTED.
- **HALTED**: `imem_ren`=0 and `halted`=1.
  - IF/ID ← bubble each cycle unless `stall`=1, in which case it holds.
  - `redirect_valid` loads PC, returns the state to RUN and bubbles IF/ID.
  - Only reset or a redirect leaves HALTED.
- Bubble = `if_id_instr` 32'h0000_0000 (sll nop), `if_id_pc4` 0, `if_id_valid` 0.
- `imem_raddr` is combinational from PC and the `WORD_ADDR` setting, and is driven in every state. ROM output is consumed only when `imem_ren`=1.

## Timing
- Reset (rst_n=0 at an edge):
  - PC = `RESET_PC`, state = BOOT.
  - `if_id_instr`=0, `if_id_pc4`=0, `if_id_valid`=0, `halted`=0.
  - `imem_ren`=0 during reset and BOOT.
- Reset asserted mid-operation overrides every other input at that edge.
- Fetch latency: the ROM read and PC update happen in the same cycle. The instruction fetched at PC=A appears on `if_id_instr` one edge later, with `if_id_pc4`=A+4.
- Redirect penalty: the redirect takes effect at the edge where it is sampled. The first target instruction is in IF/ID one edge after that. Exactly one bubble occurs.
- Stall and flush may be held for any number of cycles. `stall`+`flush` yields a bubble with PC held. `stall` has no effect on PC when `redirect_valid`=1.
- No combinational path from the `stall`, `flush` or `redirect_*` inputs to any output. `imem_raddr` depends on PC only.

## Test plan
- Reset with `RESET_PC`=0 and ROM words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0x0 -> BOOT cycle with `imem_ren`=0. Then `if_id_instr` = 0x20080001 (pc4=4), 0x20090002 (pc4=8), 0x01095020 (pc4=0xC) on consecutive edges, `imem_raddr` = 0, 1, 2.
- Stall for 3 cycles at PC=8 -> `pc_out` stays 8 and IF/ID holds 0x20090002 for 3 cycles. Releasing the stall resumes with 0x01095020.
- Redirect to 0x0000_0043 while `stall`=1 at PC=4 -> PC=0x40, one bubble (`if_id_valid`=0), then `if_id_pc4`=0x44.
- Word 5 = 0x0000_000D -> IF/ID holds the `break` with valid=1. `halted`=1, `imem_ren`=0, PC=0x14, bubbles follow. A redirect to 0 resumes fetch from 0 after one bubble.
- PC = 0xFFFF_FFFC with normal fetch -> next `pc_out`=0 and `if_id_pc4`=0. With `WORD_ADDR`=0, `imem_raddr`=0xFFFF_FFFC.
- `rst_n`=0 asserted while in RUN at PC=0x20 -> next edge gives PC=`RESET_PC`, `if_id_valid`=0 and BOOT with `imem_ren`=0.
